// File: rtl/eviction_wb_buffer_if.sv
// Bus bundle for the eviction write-back buffer: the cache-side enqueue and
// lookup signals, the memory-side write/response handshake, and status flags.
// The slave modport is the buffer itself; the master modport is its environment.
interface eviction_wb_buffer_if #(
  parameter int width      = 128,
  parameter int addr_width = 16
);
  logic                  evict_write;
  logic [addr_width-1:0] evict_addr;
  logic [width-1:0]      evict_data;
  logic                  evict_ready;
  logic [addr_width-1:0] lookup_addr;
  logic                  lookup_hit;
  logic [width-1:0]      lookup_data;
  logic [addr_width-1:0] mem_addr;
  logic [width-1:0]      mem_wdata;
  logic                  mem_write;
  logic                  mem_resp;
  logic                  empty;
  logic                  full;

  modport slave (
    input  evict_write, evict_addr, evict_data, lookup_addr, mem_resp,
    output evict_ready, lookup_hit, lookup_data, mem_addr, mem_wdata,
           mem_write, empty, full
  );

  modport master (
    output evict_write, evict_addr, evict_data, lookup_addr, mem_resp,
    input  evict_ready, lookup_hit, lookup_data, mem_addr, mem_wdata,
           mem_write, empty, full
  );
endinterface

// File: rtl/eviction_wb_buffer.sv
// Multi-entry write-back buffer for dirty lines evicted from the L1 cache.
// Lines are queued in a circular FIFO and drained to memory one at a time
// through a write/response handshake; a fully associative lookup lets the
// miss path recover a queued line (youngest match wins).
// Optional feature: define EWB_COALESCE_EN to merge an enqueue into an
// already queued entry with the same address instead of allocating a new one
// (not allowed for the head entry while it is being written to memory).
module eviction_wb_buffer #(
  parameter int width      = 128,
  parameter int addr_width = 16,
  parameter int depth      = 4
) (
  input  logic                clk,
  input  logic                reset,
  eviction_wb_buffer_if.slave bus
);

  localparam int ptr_w = $clog2(depth);
  localparam logic [ptr_w:0] count_full = (ptr_w + 1)'(depth);

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t                state_q, state_d;
  logic [ptr_w-1:0]      head_q, head_d;
  logic [ptr_w-1:0]      tail_q, tail_d;
  logic [ptr_w:0]        count_q, count_d;
  logic [depth-1:0]      valid_q, valid_d;
  logic [addr_width-1:0] addr_q [depth];
  logic [addr_width-1:0] addr_d [depth];
  logic [width-1:0]      data_q [depth];
  logic [width-1:0]      data_d [depth];
  logic                  mem_write_q, mem_write_d;

  logic                  empty_w;
  logic                  full_w;
  logic                  pop_w;
  logic                  push_w;
  logic                  coalesce_w;
  logic                  co_hit;
  logic [ptr_w-1:0]      co_idx;
  logic                  lk_hit;
  logic [ptr_w-1:0]      lk_idx;
  logic [width-1:0]      lk_data;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == count_full);
  assign pop_w   = (state_q == WRITE) && bus.mem_resp;

  assign bus.empty       = empty_w;
  assign bus.full        = full_w;
  assign bus.evict_ready = !full_w;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = empty_w ? '0 : addr_q[head_q];
  assign bus.mem_wdata   = empty_w ? '0 : data_q[head_q];
  assign bus.lookup_hit  = lk_hit;
  assign bus.lookup_data = lk_data;

  // Associative lookup walking oldest to youngest so the youngest match wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_idx  = '0;
    for (int i = 0; i < depth; i++) begin
      lk_idx = head_q + ptr_w'(i);
      if (valid_q[lk_idx] && (addr_q[lk_idx] == bus.lookup_addr)) begin
        lk_hit  = 1'b1;
        lk_data = data_q[lk_idx];
      end
    end
  end

`ifdef EWB_COALESCE_EN
  // Find a queued entry the enqueue can merge into; the head is off limits while in flight.
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < depth; i++) begin
      if (valid_q[ptr_w'(i)] && (addr_q[ptr_w'(i)] == bus.evict_addr) &&
          !((state_q == WRITE) && (ptr_w'(i) == head_q))) begin
        co_hit = 1'b1;
        co_idx = ptr_w'(i);
      end
    end
  end

  assign coalesce_w = bus.evict_write && co_hit;
  assign push_w     = bus.evict_write && !co_hit && !full_w;
`else
  assign co_hit     = 1'b0;
  assign co_idx     = '0;
  assign coalesce_w = 1'b0;
  assign push_w     = bus.evict_write && !full_w && !co_hit;
`endif

  // Next-state logic for the FIFO storage and the two-state drain machine.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mem_write_d = mem_write_q;

    case (state_q)
      IDLE: begin
        if (!empty_w) begin
          state_d     = WRITE;
          mem_write_d = 1'b1;
        end
      end
      WRITE: begin
        if (bus.mem_resp) begin
          state_d     = IDLE;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_write_d = 1'b0;
      end
    endcase

    if (pop_w) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + ptr_w'(1);
    end

    if (push_w) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = bus.evict_addr;
      data_d[tail_q]  = bus.evict_data;
      tail_d          = tail_q + ptr_w'(1);
    end

    if (coalesce_w) begin
      data_d[co_idx] = bus.evict_data;
    end

    if (push_w && !pop_w) begin
      count_d = count_q + (ptr_w + 1)'(1);
    end else if (pop_w && !push_w) begin
      count_d = count_q - (ptr_w + 1)'(1);
    end
  end

  // State registers; reset abandons any in-flight write and invalidates every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      mem_write_q <= 1'b0;
      for (int i = 0; i < depth; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_eviction_wb_buffer.sv
// Directed bench for eviction_wb_buffer: single line round trip, fill and
// drain order, simultaneous push/pop with pointer wrap, duplicate addresses
// (expectations follow EWB_COALESCE_EN) and reset during a memory write.
module tb_eviction_wb_buffer;

  logic clk = 1'b0;
  logic reset;

  int checks_total  = 0;
  int checks_passed = 0;

  eviction_wb_buffer_if #(.width(128), .addr_width(16)) bus ();

  eviction_wb_buffer #(
    .width     (128),
    .addr_width(16),
    .depth     (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic logic [127:0] line_of(input logic [15:0] a);
    return {8{a}};
  endfunction

  task automatic check_output(input string tag, input logic [127:0] actual,
                              input logic [127:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [15:0] a, input logic [127:0] d);
    bus.evict_write = 1'b1;
    bus.evict_addr  = a;
    bus.evict_data  = d;
    tick();
    bus.evict_write = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [15:0] a,
                       input logic exp_hit, input logic [127:0] exp_data);
    bus.lookup_addr = a;
    #1;
    check_output({tag, " hit"}, bus.lookup_hit, exp_hit);
    check_output({tag, " data"}, bus.lookup_data, exp_data);
  endtask

  task automatic wait_mem_write(input string tag);
    int n = 0;
    while (!bus.mem_write && n < 20) begin
      tick();
      n++;
    end
    check_output({tag, " mem_write"}, bus.mem_write, 1'b1);
  endtask

  task automatic drain_expect(input string tag, input logic [15:0] a,
                              input logic [127:0] d);
    wait_mem_write(tag);
    check_output({tag, " mem_addr"}, bus.mem_addr, a);
    check_output({tag, " mem_wdata"}, bus.mem_wdata, d);
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.evict_write = 1'b0;
    bus.evict_addr  = '0;
    bus.evict_data  = '0;
    bus.lookup_addr = 16'h0010;
    bus.mem_resp    = 1'b0;
    #2;

    // Reset values
    check_output("rst evict_ready", bus.evict_ready, 1'b1);
    check_output("rst empty", bus.empty, 1'b1);
    check_output("rst full", bus.full, 1'b0);
    check_output("rst mem_write", bus.mem_write, 1'b0);
    check_output("rst lookup_hit", bus.lookup_hit, 1'b0);
    check_output("rst lookup_data", bus.lookup_data, 128'h0);
    check_output("rst mem_addr", bus.mem_addr, 16'h0);
    check_output("rst mem_wdata", bus.mem_wdata, 128'h0);
    tick();
    reset = 1'b0;

    // Single line round trip
    apply_stimulus(16'h0010, {16{8'hAA}});
    probe("t1 lookup", 16'h0010, 1'b1, {16{8'hAA}});
    check_output("t1 empty", bus.empty, 1'b0);
    check_output("t1 idle cycle", bus.mem_write, 1'b0);
    tick();
    check_output("t1 mem_write", bus.mem_write, 1'b1);
    check_output("t1 mem_addr", bus.mem_addr, 16'h0010);
    check_output("t1 mem_wdata", bus.mem_wdata, {16{8'hAA}});
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    check_output("t1 post mem_write", bus.mem_write, 1'b0);
    check_output("t1 post empty", bus.empty, 1'b1);
    check_output("t1 post mem_addr", bus.mem_addr, 16'h0);
    probe("t1 post lookup", 16'h0010, 1'b0, 128'h0);

    // Fill to capacity, drop a fifth request, then drain in order
    for (int k = 1; k <= 4; k++) apply_stimulus(16'(k), line_of(16'(k)));
    check_output("t2 full", bus.full, 1'b1);
    check_output("t2 evict_ready", bus.evict_ready, 1'b0);
    apply_stimulus(16'h0005, line_of(16'h0005));
    probe("t2 dropped", 16'h0005, 1'b0, 128'h0);
    check_output("t2 still full", bus.full, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      check_output("t2 drain write", bus.mem_write, 1'b1);
      check_output("t2 drain addr", bus.mem_addr, 16'(k));
      check_output("t2 drain data", bus.mem_wdata, line_of(16'(k)));
      bus.mem_resp = 1'b1;
      tick();
      bus.mem_resp = 1'b0;
      check_output("t2 gap idle", bus.mem_write, 1'b0);
      if (k < 4) tick();
    end
    check_output("t2 empty", bus.empty, 1'b1);

    // Simultaneous pop and push at count 2, then wrap-around drain
    apply_stimulus(16'h0041, line_of(16'h0041));
    apply_stimulus(16'h0042, line_of(16'h0042));
    check_output("t3 write head", bus.mem_addr, 16'h0041);
    bus.mem_resp = 1'b1;
    apply_stimulus(16'h0043, line_of(16'h0043));
    bus.mem_resp = 1'b0;
    probe("t3 popped", 16'h0041, 1'b0, 128'h0);
    probe("t3 kept", 16'h0042, 1'b1, line_of(16'h0042));
    probe("t3 pushed", 16'h0043, 1'b1, line_of(16'h0043));
    apply_stimulus(16'h0044, line_of(16'h0044));
    check_output("t3 count3 full", bus.full, 1'b0);
    apply_stimulus(16'h0045, line_of(16'h0045));
    check_output("t3 count4 full", bus.full, 1'b1);
    drain_expect("t3 d42", 16'h0042, line_of(16'h0042));
    drain_expect("t3 d43", 16'h0043, line_of(16'h0043));
    drain_expect("t3 d44", 16'h0044, line_of(16'h0044));
    drain_expect("t3 d45", 16'h0045, line_of(16'h0045));
    check_output("t3 empty", bus.empty, 1'b1);

    // Duplicate address while head 0x0030 is held in WRITE
    apply_stimulus(16'h0030, line_of(16'h0030));
    wait_mem_write("t4 head");
    apply_stimulus(16'h0020, 128'd1);
    apply_stimulus(16'h0020, 128'd2);
    probe("t4 lookup", 16'h0020, 1'b1, 128'd2);
    check_output("t4 head held", bus.mem_addr, 16'h0030);
    apply_stimulus(16'h0050, line_of(16'h0050));
`ifdef EWB_COALESCE_EN
    check_output("t4 full", bus.full, 1'b0);
    drain_expect("t4 d30", 16'h0030, line_of(16'h0030));
    drain_expect("t4 d20", 16'h0020, 128'd2);
`else
    check_output("t4 full", bus.full, 1'b1);
    drain_expect("t4 d30", 16'h0030, line_of(16'h0030));
    drain_expect("t4 d20a", 16'h0020, 128'd1);
    drain_expect("t4 d20b", 16'h0020, 128'd2);
`endif
    drain_expect("t4 d50", 16'h0050, line_of(16'h0050));
    check_output("t4 empty", bus.empty, 1'b1);

    // Reset in the middle of a memory write
    apply_stimulus(16'h0060, line_of(16'h0060));
    apply_stimulus(16'h0061, line_of(16'h0061));
    wait_mem_write("t5 pre");
    check_output("t5 pre addr", bus.mem_addr, 16'h0060);
    #2;
    reset = 1'b1;
    #1;
    check_output("t5 mem_write drop", bus.mem_write, 1'b0);
    check_output("t5 empty", bus.empty, 1'b1);
    probe("t5 miss60", 16'h0060, 1'b0, 128'h0);
    probe("t5 miss61", 16'h0061, 1'b0, 128'h0);
    tick();
    reset        = 1'b0;
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    check_output("t5 resp ignored write", bus.mem_write, 1'b0);
    check_output("t5 resp ignored empty", bus.empty, 1'b1);
    apply_stimulus(16'h0070, line_of(16'h0070));
    drain_expect("t5 d70", 16'h0070, line_of(16'h0070));
    check_output("t5 final empty", bus.empty, 1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
